// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter: default sizing,
// FSM state encodings and a one-hot helper.
package fifo_rd_arbiter_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int BURST_MAX_DEF = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int ONEHOT_W = 32;

  // Callers narrow the result to their own vector width with a size cast.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping modulo NREQ, with 'last' itself considered at the very end.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    found
);

  localparam int OW = $clog2(NREQ);

  logic [OW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin owner of the single FIFO read port; grants one consumer for up
// to BURST_MAX pops and flags the matching registered read data a cycle later.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         rd_req,
  input  logic                    fifo_empty_wire,
  output logic                    rd,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [NREQ-1:0]         rd_ack,
  output logic [NREQ-1:0]         rd_valid
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  logic          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [OW-1:0] owner_nxt;
  logic [OW-1:0] last_owner, last_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;

  logic [OW-1:0] pick_last, pick_idx;
  logic          pick_found;
  logic          accept, release_grant;

  // While granted the search starts after the current owner; from idle it
  // starts after whoever held the port last.
  assign pick_last = (state == ST_GRANT) ? owner : last_owner;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (rd_req),
    .last  (pick_last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      burst_cnt  <= '0;
      rd_valid   <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      burst_cnt  <= cnt_nxt;
      rd_valid   <= rd_ack;
    end
  end

  // A pop on the releasing edge is still charged to the outgoing owner.
  assign release_grant = (accept && (burst_cnt == CW'(BURST_MAX - 1))) || !rd_req[owner];

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last_owner;
    cnt_nxt   = burst_cnt;
    if (state == ST_IDLE) begin
      if (pick_found) begin
        state_nxt = ST_GRANT;
        owner_nxt = pick_idx;
        gnt_nxt   = NREQ'(onehot(32'(pick_idx)));
        cnt_nxt   = '0;
      end
    end else begin
      if (accept) cnt_nxt = burst_cnt + CW'(1);
      if (release_grant) begin
        last_nxt = owner;
        cnt_nxt  = '0;
        if (pick_found) begin
          owner_nxt = pick_idx;
          gnt_nxt   = NREQ'(onehot(32'(pick_idx)));
        end else begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end
      end
    end
  end

  always_comb begin
    busy   = (state == ST_GRANT);
    rd     = busy && rd_req[owner];
    accept = rd && !fifo_empty_wire;
    rd_ack = accept ? NREQ'(onehot(32'(owner))) : '0;
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized bench for fifo_rd_arbiter against a cycle-level reference model
// of the round-robin grant rules.
module tb_fifo_rd_arbiter;

  localparam int NREQ      = 4;
  localparam int BURST_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] rd_req;
  logic            fifo_empty_wire;
  logic            rd;
  logic [NREQ-1:0] gnt;
  logic [1:0]      owner;
  logic            busy;
  logic [NREQ-1:0] rd_ack;
  logic [NREQ-1:0] rd_valid;

  fifo_rd_arbiter #(.NREQ(NREQ), .BURST_MAX(BURST_MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_req          (rd_req),
    .fifo_empty_wire (fifo_empty_wire),
    .rd              (rd),
    .gnt             (gnt),
    .owner           (owner),
    .busy            (busy),
    .rd_ack          (rd_ack),
    .rd_valid        (rd_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit              m_busy;
  int              m_owner;
  int              m_last;
  int              m_words;   // pops granted to the current owner so far
  logic [NREQ-1:0] m_valid;
  bit              m_acc;

  int obs_acks;
  int obs_valids;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [NREQ-1:0] req, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_words = 0;
    m_valid = '0;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_ack;
    bit              e_rd;
    e_rd  = m_busy && rd_req[m_owner];
    m_acc = e_rd && !fifo_empty_wire;
    e_gnt = m_busy ? NREQ'(1 << m_owner) : '0;
    e_ack = m_acc ? NREQ'(1 << m_owner) : '0;
    check("busy", busy, m_busy);
    check("rd", rd, e_rd);
    check("gnt", gnt, e_gnt);
    check("rd_ack", rd_ack, e_ack);
    check("rd_valid", rd_valid, m_valid);
    if (m_busy) check("owner", owner, m_owner);
    check("ack_onehot", ($countones(rd_ack) <= 1), 1);
    check("ack_when_empty", (rd_ack != 0) && fifo_empty_wire, 0);
    if (rd_ack != 0) obs_acks++;
    if (rd_valid != 0) obs_valids++;
  endtask

  // Advances the model across one rising edge using the inputs held over the cycle.
  task automatic model_step();
    logic [NREQ-1:0] req;
    int              nxt;
    req = rd_req;
    m_valid = m_acc ? NREQ'(1 << m_owner) : '0;
    if (!m_busy) begin
      nxt = pick(req, m_last);
      if (nxt >= 0) begin
        m_busy  = 1;
        m_owner = nxt;
        m_words = 0;
      end
    end else begin
      if (m_acc) m_words++;
      if (m_words == BURST_MAX || !req[m_owner]) begin
        m_last = m_owner;
        nxt    = pick(req, m_owner);
        m_words = 0;
        if (nxt >= 0) m_owner = nxt;
        else          m_busy  = 0;
      end
    end
    check("burst_limit", (m_words <= BURST_MAX), 1);
  endtask

  task automatic cycle(input logic [NREQ-1:0] req, input logic emp);
    rd_req          = req;
    fifo_empty_wire = emp;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_rd", rd, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", rd_ack, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_owner", owner, 0);
    model_reset();
    @(posedge clk);
    #2 check("rst_valid_hold", rd_valid, 0);
    rst_n = 1'b1;
    cycle(4'b0100, 1'b0);
    check("t6_gnt", gnt, 4'b0100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] req;
    logic            emp;
    int              fifo_words;
    int              next_rst;
    int              empty_pct;

    rst_n           = 1'b0;
    rd_req          = '0;
    fifo_empty_wire = 1'b1;
    model_reset();
    @(negedge clk);
    check("init_busy", busy, 0);
    check("init_gnt", gnt, 0);
    check("init_rd", rd, 0);
    check("init_ack", rd_ack, 0);
    check("init_valid", rd_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // sole requester draining a 6-word FIFO across a burst boundary
    fifo_words = 6;
    obs_acks   = 0;
    obs_valids = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0001, fifo_words == 0);
      if (m_acc) fifo_words--;
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check("t1_acks", obs_acks, 6);
    check("t1_valids", obs_valids, 6);
    check("t1_idle", busy, 0);

    // two contenders sharing a 10-word FIFO
    fifo_words = 10;
    obs_acks   = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(4'b0011, fifo_words == 0);
      if (m_acc) fifo_words--;
    end
    cycle(4'b0000, 1'b1);
    check("t2_acks", obs_acks, 10);

    // randomized traffic with varying empty pressure and occasional resets
    req      = '0;
    next_rst = 400;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       empty_pct = 0;
        1:       empty_pct = 25;
        default: empty_pct = 70;
      endcase
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      emp = ($urandom_range(0, 99) < empty_pct);
      cycle(req, emp);
      if (i >= next_rst && m_valid != 0) begin
        mid_reset();
        req      = 4'b0100;
        next_rst = i + 700;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
